seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Multi-cycle 16-bit ALU that sits directly upstream of the accumulator register.
- Single-cycle ops: add, sub, logic. Iterative ops: shift-add multiply, one-bit-per-cycle barrel-free shift.
- Delivers a registered result and flags with a one-cycle done pulse. The done pulse drives the accumulator write enable; the result drives the accumulator data input.

Parameters:
- WIDTH, 16, datapath width of operands and result.
- SHAMT_W, 4, shift-amount width (log2 WIDTH).

Ports:
- alu_clk  in  1  clock, rising edge.
- alu_rst_n  in  1  asynchronous, active-low reset.
- alu_start  in  1  op request; sampled only in IDLE.
- alu_op  in  4  opcode.
- alu_a  in  WIDTH  operand A.
- alu_b  in  WIDTH  operand B; for SHIFT, b[SHAMT_W] = direction and b[SHAMT_W-1:0] = amount.
- alu_result  out  WIDTH  registered result; held until next done.
- alu_done  out  1  one-cycle pulse, result/flags valid.
- alu_busy  out  1  high from the cycle after accepted start until done inclusive.
- alu_zero  out  1  result == 0.
- alu_carry  out  1  carry/borrow/lost bits, per op.
- alu_neg  out  1  result MSB.
- alu_ovf  out  1  signed overflow (ADD/SUB only).
- alu_illegal  out  1  opcode 8..15 received.

Behaviour:
- Reset (alu_rst_n low, async): state=IDLE; all outputs 0; internal operand, counter and accumulator regs 0. Effective immediately, including mid-operation; the in-flight op is discarded and no done is issued.
- Opcodes: 0 ADD, 1 SUB (a-b), 2 AND, 3 OR, 4 XOR, 5 NOT (~a, b ignored), 6 MUL (low WIDTH bits of a*b, unsigned), 7 SHIFT, 8-15 illegal.
- States: IDLE, MUL, SHIFT, DONE.
- IDLE: on alu_start=1, latch op/a/b.
  - Ops 0-5 and illegal go to DONE, with the result computed on this edge.
  - MUL goes to MUL with cnt=0 and acc=0.
  - SHIFT with amount=0 goes to DONE, result=a, carry=0.
  - SHIFT with amount>0 goes to SHIFT with cnt=amount.
- MUL: each cycle, if b_reg[0] then acc += a_reg (full 2*WIDTH accumulate); then a_reg <<= 1, b_reg >>= 1, cnt++. After WIDTH iterations go to DONE.
  - result = acc[WIDTH-1:0].
  - carry = |acc[2*WIDTH-1:WIDTH].
- SHIFT: one bit per cycle; direction 1 = left, 0 = right (logical, zero fill). carry = last bit shifted out. cnt decrements; at cnt==1 the final shift occurs and the state goes to DONE.
- DONE: alu_done=1 for exactly one cycle; result/flags registered on the edge entering DONE; next state IDLE. alu_start in DONE is ignored.
- Latency, from the start-sampling edge to done high:
  - ADD/SUB/logic/illegal/SHIFT-0: 1 cycle.
  - SHIFT n: n+1 cycles.
  - MUL: WIDTH+1 (17) cycles.
- alu_busy = state != IDLE.
- alu_start while busy: ignored, no queueing, latched operands unaffected.
- Operand inputs may change freely after the accepting edge.
- Flags:
  - zero/neg from the final result for all ops.
  - ADD: carry = carry-out; ovf = (a[msb]==b[msb]) && (r[msb]!=a[msb]).
  - SUB: carry = borrow (a<b unsigned); ovf = (a[msb]!=b[msb]) && (r[msb]!=a[msb]).
  - Logic ops: carry=0, ovf=0.
  - MUL/SHIFT: ovf=0.
- Illegal opcode: result=0, zero=1, other flags 0, alu_illegal=1 with done. alu_illegal clears on the next accepted start.
- result/flags persist after done until the next DONE entry or reset.
- Back-to-back: earliest next start is sampled in the cycle after done (IDLE), giving at most one op every 2 cycles.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams (OP_ADD..OP_SHIFT);
  - state encoding (ST_IDLE, ST_MUL, ST_SHIFT, ST_DONE);
  - WIDTH default.
- One natural sub-module, alu_comb_unit: purely combinational ADD/SUB/AND/OR/XOR/NOT, producing result plus carry/ovf.
- The FSM, MUL and SHIFT iteration stay in seq_alu.

Test Plan:
- ADD a=0x7FFF b=0x0001 -> done 1 cycle after start; result=0x8000, neg=1, ovf=1, carry=0, zero=0.
- SUB a=0x0003 b=0x0005 -> result=0xFFFE, carry=1, neg=1, ovf=0. Then ADD 0xFFFF+0x0001 -> result=0x0000, zero=1, carry=1.
- MUL a=0x0100 b=0x0100 -> done 17 cycles after start, busy high for those 17 cycles; result=0x0000, carry=1, zero=1. Then MUL 0x0012*0x0034 -> 0x03A8, carry=0.
- SHIFT a=0x0001 b=0x0013 (left, 3) -> done after 4 cycles, result=0x0008, carry=0. SHIFT a=0x8001 b=0x0001 (right, 1) -> result=0x4000, carry=1, latency 2. SHIFT amount 0 -> result=a, latency 1.
- Mid-MUL: pulse alu_start with different operands at cycle 5 -> ignored, result still from the original operands. Assert alu_rst_n=0 at cycle 8 -> outputs 0 immediately, busy=0, no done after release.
- Opcode 0xF -> done after 1 cycle, alu_illegal=1, result=0, zero=1. Next ADD clears alu_illegal.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states and flag bundle.
package alu_pkg;

  localparam int unsigned ALU_WIDTH   = 16;
  localparam int unsigned ALU_SHAMT_W = 4;
  localparam int unsigned OP_W        = 4;

  localparam logic [OP_W-1:0] OP_ADD   = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB   = 4'd1;
  localparam logic [OP_W-1:0] OP_AND   = 4'd2;
  localparam logic [OP_W-1:0] OP_OR    = 4'd3;
  localparam logic [OP_W-1:0] OP_XOR   = 4'd4;
  localparam logic [OP_W-1:0] OP_NOT   = 4'd5;
  localparam logic [OP_W-1:0] OP_MUL   = 4'd6;
  localparam logic [OP_W-1:0] OP_SHIFT = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MUL   = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic zero;
    logic carry;
    logic neg;
    logic ovf;
    logic illegal;
  } alu_flags_t;

endpackage

// File: rtl/alu_comb_unit.sv
// Single-cycle ALU ops (ADD/SUB/AND/OR/XOR/NOT); other opcodes yield all zeros.
module alu_comb_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic [OP_W-1:0]  op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_c,
  output logic             carry_c,
  output logic             ovf_c
);

  logic [WIDTH:0] sum_c;
  logic [WIDTH:0] diff_c;

  // Extra top bit carries the carry-out for ADD and the borrow for SUB.
  assign sum_c  = {1'b0, a_i} + {1'b0, b_i};
  assign diff_c = {1'b0, a_i} - {1'b0, b_i};

  always_comb begin
    result_c = '0;
    carry_c  = 1'b0;
    ovf_c    = 1'b0;
    case (op_i)
      OP_ADD: begin
        result_c = sum_c[WIDTH-1:0];
        carry_c  = sum_c[WIDTH];
        ovf_c    = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum_c[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_SUB: begin
        result_c = diff_c[WIDTH-1:0];
        carry_c  = diff_c[WIDTH];
        ovf_c    = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff_c[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_AND:  result_c = a_i & b_i;
      OP_OR:   result_c = a_i | b_i;
      OP_XOR:  result_c = a_i ^ b_i;
      OP_NOT:  result_c = ~a_i;
      default: result_c = '0;
    endcase
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU feeding the accumulator: single-cycle ops via alu_comb_unit,
// iterative shift-add multiply and one-bit-per-cycle shift, registered result/flags.
module seq_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = ALU_WIDTH,
  parameter int unsigned SHAMT_W = ALU_SHAMT_W
) (
  input  logic             alu_clk,
  input  logic             alu_rst_n,
  input  logic             alu_start,
  input  logic [OP_W-1:0]  alu_op,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  output logic [WIDTH-1:0] alu_result,
  output logic             alu_done,
  output logic             alu_busy,
  output logic             alu_zero,
  output logic             alu_carry,
  output logic             alu_neg,
  output logic             alu_ovf,
  output logic             alu_illegal
);

  localparam int unsigned CNT_W = SHAMT_W + 1;
  localparam int unsigned ACC_W = 2 * WIDTH;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] a_q, a_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] result_q, result_d;
  alu_flags_t       flags_q, flags_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] comb_result_c;
  logic             comb_carry_c;
  logic             comb_ovf_c;

  logic [ACC_W-1:0] mul_acc_c;
  logic [WIDTH-1:0] sh_in_c;
  logic [WIDTH-1:0] sh_out_c;
  logic             sh_bit_c;

  logic             fin_en_c;
  logic [WIDTH-1:0] fin_result_c;
  logic             fin_carry_c;
  logic             fin_ovf_c;
  logic             fin_illegal_c;

  alu_comb_unit #(.WIDTH(WIDTH)) u_comb (
    .op_i     (alu_op),
    .a_i      (alu_a),
    .b_i      (alu_b),
    .result_c (comb_result_c),
    .carry_c  (comb_carry_c),
    .ovf_c    (comb_ovf_c)
  );

  // One shift-add step and one single-bit shift step, used by their iteration states.
  assign mul_acc_c = acc_q + (b_q[0] ? a_q : '0);
  assign sh_in_c   = a_q[WIDTH-1:0];
  assign sh_out_c  = dir_q ? {sh_in_c[WIDTH-2:0], 1'b0} : {1'b0, sh_in_c[WIDTH-1:1]};
  assign sh_bit_c  = dir_q ? sh_in_c[WIDTH-1] : sh_in_c[0];

  // Next-state, datapath and output update.
  always_comb begin
    state_d       = state_q;
    a_d           = a_q;
    acc_d         = acc_q;
    b_d           = b_q;
    cnt_d         = cnt_q;
    dir_d         = dir_q;
    result_d      = result_q;
    flags_d       = flags_q;
    fin_en_c      = 1'b0;
    fin_result_c  = '0;
    fin_carry_c   = 1'b0;
    fin_ovf_c     = 1'b0;
    fin_illegal_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (alu_start) begin
          a_d             = ACC_W'(alu_a);
          b_d             = alu_b;
          dir_d           = alu_b[SHAMT_W];
          cnt_d           = '0;
          acc_d           = '0;
          flags_d.illegal = 1'b0;
          if (alu_op == OP_MUL) begin
            state_d = ST_MUL;
          end else if (alu_op == OP_SHIFT) begin
            if (alu_b[SHAMT_W-1:0] == '0) begin
              fin_en_c     = 1'b1;
              fin_result_c = alu_a;
            end else begin
              state_d = ST_SHIFT;
              cnt_d   = CNT_W'(alu_b[SHAMT_W-1:0]);
            end
          end else begin
            fin_en_c      = 1'b1;
            fin_result_c  = comb_result_c;
            fin_carry_c   = comb_carry_c;
            fin_ovf_c     = comb_ovf_c;
            fin_illegal_c = (alu_op > OP_SHIFT);
          end
        end
      end
      ST_MUL: begin
        acc_d = mul_acc_c;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          fin_en_c     = 1'b1;
          fin_result_c = mul_acc_c[WIDTH-1:0];
          fin_carry_c  = |mul_acc_c[ACC_W-1:WIDTH];
        end
      end
      ST_SHIFT: begin
        a_d   = ACC_W'(sh_out_c);
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          fin_en_c     = 1'b1;
          fin_result_c = sh_out_c;
          fin_carry_c  = sh_bit_c;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Result and flags are captured only on the edge that enters DONE.
    if (fin_en_c) begin
      state_d         = ST_DONE;
      result_d        = fin_result_c;
      flags_d.zero    = (fin_result_c == '0);
      flags_d.neg     = fin_result_c[WIDTH-1];
      flags_d.carry   = fin_carry_c;
      flags_d.ovf     = fin_ovf_c;
      flags_d.illegal = fin_illegal_c;
    end

    done_d = (state_d == ST_DONE);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge alu_clk or negedge alu_rst_n) begin
    if (!alu_rst_n) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      acc_q    <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      dir_q    <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign alu_result  = result_q;
  assign alu_done    = done_q;
  assign alu_busy    = busy_q;
  assign alu_zero    = flags_q.zero;
  assign alu_carry   = flags_q.carry;
  assign alu_neg     = flags_q.neg;
  assign alu_ovf     = flags_q.ovf;
  assign alu_illegal = flags_q.illegal;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: directed ops push expectations, a monitor checks each done.
module tb_seq_alu;

  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND_ = 4'd2, OR_ = 4'd3;
  localparam logic [3:0] XOR_ = 4'd4, NOT_ = 4'd5, MUL = 4'd6, SHF = 4'd7;

  typedef struct {
    string       tag;
    logic [15:0] r;
    logic        z, c, n, o, il;
    int          exp_cyc;
  } exp_t;

  logic        alu_clk = 1'b0;
  logic        alu_rst_n;
  logic        alu_start;
  logic [3:0]  alu_op;
  logic [15:0] alu_a, alu_b;
  logic [15:0] alu_result;
  logic        alu_done, alu_busy, alu_zero, alu_carry, alu_neg, alu_ovf, alu_illegal;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sb[$];

  seq_alu dut (
    .alu_clk     (alu_clk),
    .alu_rst_n   (alu_rst_n),
    .alu_start   (alu_start),
    .alu_op      (alu_op),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_result  (alu_result),
    .alu_done    (alu_done),
    .alu_busy    (alu_busy),
    .alu_zero    (alu_zero),
    .alu_carry   (alu_carry),
    .alu_neg     (alu_neg),
    .alu_ovf     (alu_ovf),
    .alu_illegal (alu_illegal)
  );

  always #5 alu_clk = ~alu_clk;
  always @(posedge alu_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge alu_clk) begin
    if (alu_rst_n && alu_done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done got=1 exp=0 at cyc %0d", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.tag, ".result"},  32'(alu_result),  32'(e.r));
        check({e.tag, ".zero"},    32'(alu_zero),    32'(e.z));
        check({e.tag, ".carry"},   32'(alu_carry),   32'(e.c));
        check({e.tag, ".neg"},     32'(alu_neg),     32'(e.n));
        check({e.tag, ".ovf"},     32'(alu_ovf),     32'(e.o));
        check({e.tag, ".illegal"}, 32'(alu_illegal), 32'(e.il));
        check({e.tag, ".latency"}, 32'(cyc),         32'(e.exp_cyc));
      end
    end
  end

  // Issue one op, push its expectation, optionally poke a start while busy at step intf.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] r, input logic z,
                        input logic c, input logic n, input logic o, input logic il,
                        input int lat, input int intf);
    exp_t e;
    int   busy_cnt = 0;
    bit   seen = 0;
    @(negedge alu_clk);
    alu_start = 1'b1;
    alu_op = op;
    alu_a = a;
    alu_b = b;
    e.tag = tag; e.r = r; e.z = z; e.c = c; e.n = n; e.o = o; e.il = il;
    e.exp_cyc = cyc + lat;
    sb.push_back(e);
    for (int k = 1; k <= 40; k++) begin
      @(negedge alu_clk);
      if (k == intf) begin
        alu_start = 1'b1;
        alu_op = ADD;
        alu_a = 16'h1111;
        alu_b = 16'h2222;
      end else begin
        alu_start = 1'b0;
        alu_a = 16'hDEAD;
        alu_b = 16'hBEEF;
      end
      if (alu_busy) busy_cnt++;
      if (alu_done) begin
        seen = 1;
        break;
      end
    end
    alu_start = 1'b0;
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s.timeout got=no_done exp=done", tag);
    end
    check({tag, ".busy_cycles"}, 32'(busy_cnt), 32'(lat));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".result"}, 32'(alu_result), 32'h0);
    check({tag, ".flags"}, 32'({alu_done, alu_busy, alu_zero, alu_carry, alu_neg, alu_ovf, alu_illegal}), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    alu_rst_n = 1'b0;
    alu_start = 1'b0;
    alu_op = '0;
    alu_a = '0;
    alu_b = '0;
    repeat (2) @(negedge alu_clk);
    check_all_zero("reset");
    alu_rst_n = 1'b1;

    //      tag        op    a         b         result    z  c  n  o  il lat intf
    run_op("add_ovf",  ADD,  16'h7FFF, 16'h0001, 16'h8000, 0, 0, 1, 1, 0, 1,  0);
    run_op("sub_brw",  SUB,  16'h0003, 16'h0005, 16'hFFFE, 0, 1, 1, 0, 0, 1,  0);
    run_op("add_wrap", ADD,  16'hFFFF, 16'h0001, 16'h0000, 1, 1, 0, 0, 0, 1,  0);
    run_op("sub_ovf",  SUB,  16'h8000, 16'h0001, 16'h7FFF, 0, 0, 0, 1, 0, 1,  0);
    run_op("and",      AND_, 16'hF0F0, 16'h3C3C, 16'h3030, 0, 0, 0, 0, 0, 1,  0);
    run_op("or",       OR_,  16'hF0F0, 16'h3C3C, 16'hFCFC, 0, 0, 1, 0, 0, 1,  0);
    run_op("xor",      XOR_, 16'hF0F0, 16'h3C3C, 16'hCCCC, 0, 0, 1, 0, 0, 1,  0);
    run_op("not",      NOT_, 16'hFFFF, 16'h1234, 16'h0000, 1, 0, 0, 0, 0, 1,  0);
    run_op("mul_hi",   MUL,  16'h0100, 16'h0100, 16'h0000, 1, 1, 0, 0, 0, 17, 0);
    run_op("mul_lo",   MUL,  16'h0012, 16'h0034, 16'h03A8, 0, 0, 0, 0, 0, 17, 0);
    run_op("mul_max",  MUL,  16'hFFFF, 16'hFFFF, 16'h0001, 0, 1, 0, 0, 0, 17, 0);
    run_op("shl3",     SHF,  16'h0001, 16'h0013, 16'h0008, 0, 0, 0, 0, 0, 4,  0);
    run_op("shr1",     SHF,  16'h8001, 16'h0001, 16'h4000, 0, 1, 0, 0, 0, 2,  0);
    run_op("sh0",      SHF,  16'h1234, 16'h0010, 16'h1234, 0, 0, 0, 0, 0, 1,  0);
    run_op("shr15",    SHF,  16'h8000, 16'h000F, 16'h0001, 0, 0, 0, 0, 0, 16, 0);
    run_op("shl15",    SHF,  16'h0003, 16'h001F, 16'h8000, 0, 1, 1, 0, 0, 16, 0);
    run_op("illegal",  4'hF, 16'h1234, 16'h5678, 16'h0000, 1, 0, 0, 0, 1, 1,  0);
    run_op("add_clr",  ADD,  16'h0002, 16'h0003, 16'h0005, 0, 0, 0, 0, 0, 1,  0);
    run_op("mul_intf", MUL,  16'h0012, 16'h0034, 16'h03A8, 0, 0, 0, 0, 0, 17, 5);

    // Reset mid-multiply: outputs clear at once and the aborted op never completes.
    @(negedge alu_clk);
    alu_start = 1'b1;
    alu_op = MUL;
    alu_a = 16'h0005;
    alu_b = 16'h0007;
    for (int k = 1; k <= 8; k++) begin
      @(negedge alu_clk);
      alu_start = 1'b0;
    end
    check("mid_mul.busy_before", 32'(alu_busy), 32'h1);
    alu_rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid_mul");
    @(negedge alu_clk);
    alu_rst_n = 1'b1;
    repeat (30) @(negedge alu_clk);
    check_all_zero("after_rst");

    run_op("post_rst", ADD, 16'h1000, 16'h2000, 16'h3000, 0, 0, 0, 0, 0, 1, 0);
    repeat (3) @(negedge alu_clk);
    check("sb_empty", 32'(sb.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
